prog_uart_tx: RTL and testbench
===============================

# prog_uart_tx

Buffered 8N1 UART transmitter, the transmit-side counterpart of the programming UART receiver in `prog_uart_top`. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them LSB-first on `tx_o`. The bit period comes from the same run-time `CLK_PER_BIT` value the receiver uses, sourced from the logic analyser. It sits inside the SoC top and drives the host-facing TX pad, returning acknowledge and echo bytes during programming.

## Interface
- `DATA_W`, 8, payload bits per frame.
- `FIFO_DEPTH`, 4, FIFO entries; must be a power of 2 and at least 2.
- `CPB_W`, 16, width of the bit-period input.
- `clock` input 1: single clock for the whole block.
- `reset_n` input 1: asynchronous, active-low reset.
- `clk_per_bit` input CPB_W: clock cycles per UART bit.
- `tx_data_i` input DATA_W: byte to send.
- `tx_valid_i` input 1: `tx_data_i` is valid.
- `tx_ready_o` output 1: FIFO can accept a byte.
- `tx_o` output 1: serial line, idles high, registered.
- `busy_o` output 1: a frame is in flight or the FIFO is non-empty.
- `fifo_count_o` output $clog2(FIFO_DEPTH)+1: number of bytes currently buffered.

## Operation
- **Push.** A byte is accepted on a rising edge where `tx_valid_i && tx_ready_o`. `tx_ready_o = !full` is combinational from the FIFO count only. When the FIFO is full, a push is refused even if a pop happens in the same cycle.
- **FSM states:** IDLE, START, DATA, PARITY (present only with the macro), STOP.
- **IDLE → START.** Taken when the FIFO is non-empty. On that edge the head byte is popped into the shift register, `clk_per_bit` is latched, and `tx_o` is driven to 0.
- **Latched bit period.** `lat_cpb = max(clk_per_bit, 2)`. Changes to `clk_per_bit` mid-frame have no effect until the next frame starts.
- **Baud counter.** Counts 0 .. `lat_cpb`-1. Each bit is held for exactly `lat_cpb` cycles, and the state advances when the counter wraps.
- **DATA.** Sends `DATA_W` bits, LSB first; an internal bit index counts 0..DATA_W-1.
- **STOP.** Drives `tx_o` = 1 for one bit period. At the end of STOP:
  - FIFO non-empty: go directly to START, popping the next byte on the same edge. There is no idle gap between frames.
  - Otherwise: go to IDLE.
- **Simultaneous push and pop** in a non-full FIFO: the count is unchanged and both operations complete.
- **Reset,** at any time including mid-frame: `tx_o`=1, `tx_ready_o`=1, `busy_o`=0, `fifo_count_o`=0, state IDLE, counters 0. All FIFO contents are discarded.
- `busy_o = (state != IDLE) || (count != 0)`.

## Timing
- **Latency.** A byte pushed at edge N into an empty, idle block drives `tx_o` low after edge N+1.
- **Frame length.** (DATA_W+2)·`lat_cpb` cycles, or (DATA_W+3)·`lat_cpb` with parity.
- **Throughput.** Sustained back-to-back frames with no extra cycles between them.
- **Outputs.** `tx_o` changes only on clock edges (glitch-free). `fifo_count_o` updates on the edge following a push or pop.

## Configuration
- `PROG_UART_TX_PARITY_EN` defined:
  - The PARITY state is inserted between DATA and STOP.
  - It sends even parity (XOR of the data bits) for one bit period.
  - Frame length is 11 bits.
- `PROG_UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - Frame length is 10 bits.

## Structure
- Package `prog_uart_pkg` holds:
  - the FSM state enum;
  - `CPB_MIN = 2`;
  - the frame bit-count constants for both configurations.
- Sub-module `prog_uart_tx_fifo` is a synchronous FIFO with push, pop, full, empty and count, and the same reset. The top level contains the FSM, baud counter and shift register.

## Test plan
- **Reset values.** Hold `reset_n`=0, then release → `tx_o`=1, `tx_ready_o`=1, `busy_o`=0, `fifo_count_o`=0.
- **Single byte.** `clk_per_bit`=4, push 0xA5 → `tx_o` sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1. Frame totals 40 cycles, then `busy_o` falls.
- **Back-to-back.** Push 0x00, 0xFF, 0x3C on consecutive cycles → three contiguous 10-bit frames with no idle bit between them; `fifo_count_o` peaks at 2.
- **Full FIFO.** `clk_per_bit`=100, push 6 bytes while holding valid → `tx_ready_o` low after 5 accepted (1 in shift register, 4 buffered). The 6th byte is accepted only after the next pop.
- **Bit-period handling.**
  - Change `clk_per_bit` from 4 to 8 mid-frame → the current frame stays at 4 cycles per bit and the next frame uses 8.
  - `clk_per_bit`=0 → bits are 2 cycles long.
- **Reset mid-frame.**
  - Assert `reset_n` during DATA → `tx_o`=1 immediately, FIFO empty.
  - With `PROG_UART_TX_PARITY_EN`: 0x07 gives parity bit 1 and 0x03 gives parity bit 0.

Source files
------------

// File: rtl/prog_uart_tx_pkg.sv
// rtl/prog_uart_tx_pkg.sv - shared types and constants for prog_uart_tx; PROG_UART_TX_PARITY_EN adds the PARITY state
package prog_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef PROG_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

    localparam int CPB_MIN        = 2;
    localparam int FRAME_BITS_8N1 = 10;
    localparam int FRAME_BITS_8E1 = 11;

endpackage

// File: rtl/prog_uart_tx_if.sv
// rtl/prog_uart_tx_if.sv - byte push handshake between a producer and prog_uart_tx
interface prog_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;

    modport master (output tx_data_i, output tx_valid_i, input tx_ready_o);
    modport slave  (input tx_data_i, input tx_valid_i, output tx_ready_o);
endinterface

// File: rtl/prog_uart_tx_fifo.sv
// rtl/prog_uart_tx_fifo.sv - synchronous FIFO buffering bytes ahead of the UART shifter
module prog_uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prog_uart_tx.sv
// rtl/prog_uart_tx.sv - buffered 8N1 UART transmitter; define PROG_UART_TX_PARITY_EN for an even parity bit
module prog_uart_tx
    import prog_uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CPB_W      = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [CPB_W-1:0]            clk_per_bit,
    prog_uart_tx_if.slave               bus,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

    localparam int BIT_W = $clog2(DATA_W);

    tx_state_t         state_q, state_d;
    logic [CPB_W-1:0]  baud_q, baud_d;
    logic [CPB_W-1:0]  lat_cpb_q, lat_cpb_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              load;
    logic              baud_wrap;
    logic              last_bit;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
`ifdef PROG_UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    prog_uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (bus.tx_valid_i),
        .push_data (bus.tx_data_i),
        .pop       (load),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_o)
    );

    assign bus.tx_ready_o = !fifo_full;
    assign busy_o         = (state_q != ST_IDLE) || (fifo_count_o != '0);
    assign tx_o           = tx_q;
    assign baud_wrap      = (baud_q == lat_cpb_q - 1'b1);
    assign last_bit       = (bit_q == BIT_W'(DATA_W - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_START;
            ST_START:  if (baud_wrap) state_d = ST_DATA;
`ifdef PROG_UART_TX_PARITY_EN
            ST_DATA:   if (baud_wrap && last_bit) state_d = ST_PARITY;
            ST_PARITY: if (baud_wrap) state_d = ST_STOP;
`else
            ST_DATA:   if (baud_wrap && last_bit) state_d = ST_STOP;
`endif
            ST_STOP:   if (baud_wrap) state_d = fifo_empty ? ST_IDLE : ST_START;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        lat_cpb_d = lat_cpb_q;
        baud_d    = (state_q == ST_IDLE || baud_wrap) ? '0 : baud_q + 1'b1;
`ifdef PROG_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q == ST_IDLE) begin
            load = !fifo_empty;
        end else if (baud_wrap) begin
            case (state_q)
                ST_START: tx_d = shift_q[0];
                ST_DATA: begin
                    if (last_bit) begin
                        bit_d = '0;
`ifdef PROG_UART_TX_PARITY_EN
                        tx_d  = parity_q;
`else
                        tx_d  = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
                ST_STOP: begin
                    load = !fifo_empty;
                    tx_d = 1'b1;
                end
                default: tx_d = 1'b1;
            endcase
        end
        // Popping the next byte overrides everything: start bit goes out on this edge.
        if (load) begin
            tx_d      = 1'b0;
            shift_d   = fifo_head;
            bit_d     = '0;
            baud_d    = '0;
            lat_cpb_d = (clk_per_bit < CPB_W'(CPB_MIN)) ? CPB_W'(CPB_MIN) : clk_per_bit;
`ifdef PROG_UART_TX_PARITY_EN
            parity_d  = ^fifo_head;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            baud_q    <= '0;
            lat_cpb_q <= CPB_W'(CPB_MIN);
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef PROG_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            baud_q    <= baud_d;
            lat_cpb_q <= lat_cpb_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef PROG_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_prog_uart_tx.sv
// tb/tb_prog_uart_tx.sv - directed self-checking bench for prog_uart_tx
module tb_prog_uart_tx;
    import prog_uart_pkg::*;

`ifdef PROG_UART_TX_PARITY_EN
    localparam int NBITS = FRAME_BITS_8E1;
`else
    localparam int NBITS = FRAME_BITS_8N1;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] clk_per_bit = 16'd4;
    logic        tx_o;
    logic        busy_o;
    logic [2:0]  fifo_count_o;
    int          errors = 0;
    int          checks = 0;
    int          n;

    prog_uart_tx_if #(.DATA_W(8)) bus ();

    prog_uart_tx #(.DATA_W(8), .FIFO_DEPTH(4), .CPB_W(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clk_per_bit  (clk_per_bit),
        .bus          (bus),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef PROG_UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Called at the negedge following the cycle index 'first' of a frame that started after a load edge.
    task automatic check_frame(input logic [7:0] b, input int cpb, input int first);
        for (int i = first; i < NBITS * cpb; i++) begin
            if (i == first) check($sformatf("busy in frame %h", b), busy_o, 1);
            check($sformatf("frame %h cyc %0d", b, i), tx_o, exp_bit(b, i / cpb));
            @(negedge clock);
        end
    endtask

    task automatic push_one(input logic [7:0] b);
        @(negedge clock);
        bus.tx_data_i  = b;
        bus.tx_valid_i = 1'b1;
        @(posedge clock);
        #1 bus.tx_valid_i = 1'b0;
    endtask

    initial begin
        bus.tx_data_i  = 8'h00;
        bus.tx_valid_i = 1'b0;

        // Reset values, during and after reset
        repeat (3) @(negedge clock);
        check("rst tx", tx_o, 1);
        check("rst ready", bus.tx_ready_o, 1);
        check("rst busy", busy_o, 0);
        check("rst count", fifo_count_o, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post tx", tx_o, 1);
        check("post ready", bus.tx_ready_o, 1);
        check("post busy", busy_o, 0);
        check("post count", fifo_count_o, 0);

        // Single byte 0xA5 at 4 clocks per bit
        push_one(8'hA5);
        @(negedge clock);
        check("latency idle tx", tx_o, 1);
        @(negedge clock);
        check_frame(8'hA5, 4, 0);
        check("single busy end", busy_o, 0);
        check("single tx end", tx_o, 1);

        // Back-to-back 0x00, 0xFF, 0x3C
        @(negedge clock);
        bus.tx_data_i  = 8'h00;
        bus.tx_valid_i = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.tx_data_i = 8'hFF;
        check("b2b count1", fifo_count_o, 1);
        @(posedge clock);
        @(negedge clock);
        check("b2b start", tx_o, 0);
        bus.tx_data_i = 8'h3C;
        @(posedge clock);
        #1 bus.tx_valid_i = 1'b0;
        @(negedge clock);
        check("b2b peak count", fifo_count_o, 2);
        check_frame(8'h00, 4, 1);
        check_frame(8'hFF, 4, 0);
        check_frame(8'h3C, 4, 0);
        check("b2b busy end", busy_o, 0);

        // Bit period changed mid-frame from 4 to 8
        @(negedge clock);
        bus.tx_data_i  = 8'h5A;
        bus.tx_valid_i = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.tx_data_i = 8'hC3;
        @(posedge clock);
        #1 bus.tx_valid_i = 1'b0;
        clk_per_bit = 16'd8;
        @(negedge clock);
        check_frame(8'h5A, 4, 0);
        check_frame(8'hC3, 8, 0);
        check("cpb busy end", busy_o, 0);

        // Zero bit period clamps to 2 cycles per bit
        clk_per_bit = 16'd0;
        push_one(8'h81);
        @(negedge clock);
        @(negedge clock);
        check_frame(8'h81, 2, 0);
        check("cpb0 busy end", busy_o, 0);

`ifdef PROG_UART_TX_PARITY_EN
        clk_per_bit = 16'd4;
        push_one(8'h07);
        @(negedge clock);
        @(negedge clock);
        check_frame(8'h07, 4, 0);
        push_one(8'h03);
        @(negedge clock);
        @(negedge clock);
        check_frame(8'h03, 4, 0);
`endif

        // Full FIFO with slow bit period: 5 accepted, 6th waits for the next pop
        clk_per_bit = 16'd100;
        @(negedge clock);
        bus.tx_data_i  = 8'h10;
        bus.tx_valid_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock);
            @(negedge clock);
            bus.tx_data_i = 8'h10 + 8'(k);
        end
        check("full ready", bus.tx_ready_o, 0);
        check("full count", fifo_count_o, 4);
        n = 0;
        while (!bus.tx_ready_o && n < 1200) begin
            @(negedge clock);
            n++;
        end
        check("full wait cycles", n, 997);
        check("after pop count", fifo_count_o, 3);
        @(posedge clock);
        #1 bus.tx_valid_i = 1'b0;
        @(negedge clock);
        check("refill count", fifo_count_o, 4);
        check("refill ready", bus.tx_ready_o, 0);

        // Asynchronous reset in the middle of DATA
        repeat (250) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst tx", tx_o, 1);
        check("midrst count", fifo_count_o, 0);
        check("midrst ready", bus.tx_ready_o, 1);
        check("midrst busy", busy_o, 0);
        @(negedge clock);
        reset_n = 1'b1;
        clk_per_bit = 16'd2;
        push_one(8'h3C);
        @(negedge clock);
        @(negedge clock);
        check_frame(8'h3C, 2, 0);
        check("final busy", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
